ctrl_seq_decoder: RTL and testbench

- Registered, parametrised control unit for the X9 core; successor to the flat combinational opcode decoder.
- Accepts one opcode per cycle over a valid/ready handshake and emits a registered control bundle one cycle later.
- Sequences multi-cycle operations:
  - memory ops hold the front end for a programmable wait,
  - movi hi/lo pairs are enforced,
  - branch flush kills in-flight decode.

---
 rtl/ctrl_seq_decoder_if.sv | 53 +++++
 rtl/ctrl_seq_decoder.sv | 238 +++++++++++++++++++++++
 tb/tb_ctrl_seq_decoder.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_seq_decoder_if.sv
// ctrl_seq_decoder_if - opcode handshake and control bundle between the X9
// front end (master) and the sequencing decoder (slave).
// Optional macro CTRL_PERF_EN adds the three performance counter outputs.
interface ctrl_seq_decoder_if #(
   parameter int MCODEBITS = 5,
   parameter int OPWIDTH   = 4
);
   logic                 instr_valid;
   logic                 instr_ready;
   logic [MCODEBITS-1:0] instr;
   logic                 flush;
   logic                 ctl_valid;
   logic [1:0]           InstType;
   logic                 Branch;
   logic                 MemRead;
   logic                 MemWrite;
   logic                 MemtoReg;
   logic                 ALUSrc;
   logic                 RegWrite;
   logic [OPWIDTH-1:0]   ALUOp;
   logic                 illegal;
`ifdef CTRL_PERF_EN
   logic [15:0]          perf_retired;
   logic [15:0]          perf_stall;
   logic [7:0]           perf_illegal;

   modport master (
      output instr_valid, instr, flush,
      input  instr_ready, ctl_valid, InstType, Branch, MemRead, MemWrite,
             MemtoReg, ALUSrc, RegWrite, ALUOp, illegal,
             perf_retired, perf_stall, perf_illegal
   );

   modport slave (
      input  instr_valid, instr, flush,
      output instr_ready, ctl_valid, InstType, Branch, MemRead, MemWrite,
             MemtoReg, ALUSrc, RegWrite, ALUOp, illegal,
             perf_retired, perf_stall, perf_illegal
   );
`else
   modport master (
      output instr_valid, instr, flush,
      input  instr_ready, ctl_valid, InstType, Branch, MemRead, MemWrite,
             MemtoReg, ALUSrc, RegWrite, ALUOp, illegal
   );

   modport slave (
      input  instr_valid, instr, flush,
      output instr_ready, ctl_valid, InstType, Branch, MemRead, MemWrite,
             MemtoReg, ALUSrc, RegWrite, ALUOp, illegal
   );
`endif
endinterface

// File: rtl/ctrl_seq_decoder.sv
// ctrl_seq_decoder - registered X9 control unit. Accepts one opcode per
// cycle, emits the control bundle one cycle later, stalls the front end
// after loads/stores, enforces movi hi/lo pairing and honours branch flush.
// Optional macro CTRL_PERF_EN enables saturating performance counters.
module ctrl_seq_decoder #(
   parameter int MCODEBITS = 5,
   parameter int OPWIDTH   = 4,
   parameter int MEMLAT    = 2
) (
   input logic              Clk,
   input logic              Reset,
   ctrl_seq_decoder_if.slave bus
);

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_MEMWAIT = 2'd1;
   localparam logic [1:0] ST_MOVI2   = 2'd2;

   localparam logic [3:0] C_MEMLAT = 4'(MEMLAT);

   localparam logic [MCODEBITS-1:0] OP_ADDI   = MCODEBITS'(5'b00010);
   localparam logic [MCODEBITS-1:0] OP_LB     = MCODEBITS'(5'b00011);
   localparam logic [MCODEBITS-1:0] OP_SB     = MCODEBITS'(5'b00100);
   localparam logic [MCODEBITS-1:0] OP_BEQ    = MCODEBITS'(5'b00101);
   localparam logic [MCODEBITS-1:0] OP_BNE    = MCODEBITS'(5'b00110);
   localparam logic [MCODEBITS-1:0] OP_ALUMAX = MCODEBITS'(5'b01111);
   localparam logic [MCODEBITS-1:0] OP_MOVIHI = MCODEBITS'(5'b10001);
   localparam logic [MCODEBITS-1:0] OP_MOVILO = MCODEBITS'(5'b11001);

   logic [1:0]         r_state;
   logic [3:0]         r_cnt;

   logic               r_ctlValid;
   logic [1:0]         r_instType;
   logic               r_branch;
   logic               r_memRead;
   logic               r_memWrite;
   logic               r_memtoReg;
   logic               r_aluSrc;
   logic               r_regWrite;
   logic [OPWIDTH-1:0] r_aluOp;
   logic               r_illegal;

   logic               w_ready;
   logic               w_xfer;
   logic [1:0]         w_instType;
   logic               w_branch;
   logic               w_memRead;
   logic               w_memWrite;
   logic               w_memtoReg;
   logic               w_aluSrc;
   logic               w_regWrite;
   logic [OPWIDTH-1:0] w_aluOp;
   logic               w_illegal;
   logic               w_isMem;
   logic               w_isMoviHi;

   // Ready depends on state alone so the front end never sees a loop
   // through instr_valid; a flush suppresses any transfer on its edge.
   assign w_ready = (r_state == ST_RUN) || (r_state == ST_MOVI2);
   assign w_xfer  = bus.instr_valid && w_ready && !bus.flush;

   // Opcode decode; an open movi pair turns anything but movi-lo into a
   // flagged no-op so a half-built immediate never reaches the datapath.
   always_comb begin
      w_instType = 2'd0;
      w_branch   = 1'b0;
      w_memRead  = 1'b0;
      w_memWrite = 1'b0;
      w_memtoReg = 1'b0;
      w_aluSrc   = 1'b0;
      w_regWrite = 1'b1;
      w_aluOp    = bus.instr[OPWIDTH-1:0];
      w_illegal  = 1'b0;
      w_isMem    = 1'b0;
      w_isMoviHi = 1'b0;
      case (bus.instr)
         OP_ADDI: begin
            w_aluSrc = 1'b1;
         end
         OP_LB: begin
            w_aluSrc   = 1'b1;
            w_memRead  = 1'b1;
            w_memtoReg = 1'b1;
            w_isMem    = 1'b1;
         end
         OP_SB: begin
            w_aluSrc   = 1'b1;
            w_memWrite = 1'b1;
            w_regWrite = 1'b0;
            w_isMem    = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            w_branch   = 1'b1;
            w_regWrite = 1'b0;
         end
         OP_MOVIHI: begin
            w_instType = 2'd2;
            w_aluSrc   = 1'b1;
            w_isMoviHi = 1'b1;
         end
         OP_MOVILO: begin
            w_instType = 2'd3;
            w_aluSrc   = 1'b1;
         end
         default: begin
            if (bus.instr > OP_ALUMAX) begin
               w_regWrite = 1'b0;
               w_illegal  = 1'b1;
            end
         end
      endcase
      if ((r_state == ST_MOVI2) && (bus.instr != OP_MOVILO)) begin
         w_instType = 2'd0;
         w_branch   = 1'b0;
         w_memRead  = 1'b0;
         w_memWrite = 1'b0;
         w_memtoReg = 1'b0;
         w_aluSrc   = 1'b0;
         w_regWrite = 1'b0;
         w_illegal  = 1'b1;
         w_isMem    = 1'b0;
         w_isMoviHi = 1'b0;
      end
   end

   // Sequencer: memory wait countdown and movi pairing; flush resets it.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= ST_RUN;
         r_cnt   <= 4'd0;
      end else if (bus.flush) begin
         r_state <= ST_RUN;
         r_cnt   <= 4'd0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_xfer && w_isMem && (C_MEMLAT != 4'd0)) begin
                  r_state <= ST_MEMWAIT;
                  r_cnt   <= C_MEMLAT;
               end else if (w_xfer && w_isMoviHi) begin
                  r_state <= ST_MOVI2;
               end
            end
            ST_MEMWAIT: begin
               if (r_cnt <= 4'd1) begin
                  r_state <= ST_RUN;
                  r_cnt   <= 4'd0;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_MOVI2: begin
               if (w_xfer) begin
                  r_state <= ST_RUN;
               end
            end
            default: begin
               r_state <= ST_RUN;
               r_cnt   <= 4'd0;
            end
         endcase
      end
   end

   // Output bundle register: loaded only on a transfer so ctl_valid and
   // illegal are single-cycle; flush kills whatever was being decoded.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset || bus.flush) begin
         r_ctlValid <= 1'b0;
         r_instType <= 2'd0;
         r_branch   <= 1'b0;
         r_memRead  <= 1'b0;
         r_memWrite <= 1'b0;
         r_memtoReg <= 1'b0;
         r_aluSrc   <= 1'b0;
         r_regWrite <= 1'b0;
         r_aluOp    <= '0;
         r_illegal  <= 1'b0;
      end else if (w_xfer) begin
         r_ctlValid <= 1'b1;
         r_instType <= w_instType;
         r_branch   <= w_branch;
         r_memRead  <= w_memRead;
         r_memWrite <= w_memWrite;
         r_memtoReg <= w_memtoReg;
         r_aluSrc   <= w_aluSrc;
         r_regWrite <= w_regWrite;
         r_aluOp    <= w_aluOp;
         r_illegal  <= w_illegal;
      end else begin
         r_ctlValid <= 1'b0;
         r_illegal  <= 1'b0;
      end
   end

   assign bus.instr_ready = w_ready;
   assign bus.ctl_valid   = r_ctlValid;
   assign bus.InstType    = r_instType;
   assign bus.Branch      = r_branch;
   assign bus.MemRead     = r_memRead;
   assign bus.MemWrite    = r_memWrite;
   assign bus.MemtoReg    = r_memtoReg;
   assign bus.ALUSrc      = r_aluSrc;
   assign bus.RegWrite    = r_regWrite;
   assign bus.ALUOp       = r_aluOp;
   assign bus.illegal     = r_illegal;

`ifdef CTRL_PERF_EN
   logic [15:0] r_perfRetired;
   logic [15:0] r_perfStall;
   logic [7:0]  r_perfIllegal;

   // Saturating event counters; only Reset clears them, flush leaves them.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_perfRetired <= '0;
         r_perfStall   <= '0;
         r_perfIllegal <= '0;
      end else begin
         if (r_ctlValid && !r_illegal && (r_perfRetired != 16'hFFFF)) begin
            r_perfRetired <= r_perfRetired + 16'd1;
         end
         if (bus.instr_valid && !w_ready && (r_perfStall != 16'hFFFF)) begin
            r_perfStall <= r_perfStall + 16'd1;
         end
         if (r_illegal && (r_perfIllegal != 8'hFF)) begin
            r_perfIllegal <= r_perfIllegal + 8'd1;
         end
      end
   end

   assign bus.perf_retired = r_perfRetired;
   assign bus.perf_stall   = r_perfStall;
   assign bus.perf_illegal = r_perfIllegal;
`endif

endmodule

// File: tb/tb_ctrl_seq_decoder.sv
// tb_ctrl_seq_decoder - directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
// Define CTRL_PERF_EN to also exercise the performance counters.
module tb_ctrl_seq_decoder;

   localparam int MCODEBITS = 5;
   localparam int OPWIDTH   = 4;
   localparam int MEMLAT    = 2;

   typedef struct packed {
      logic [1:0] instType;
      logic       branch;
      logic       memRead;
      logic       memWrite;
      logic       memtoReg;
      logic       aluSrc;
      logic       regWrite;
      logic [3:0] aluOp;
      logic       illegal;
   } bundle_t;

   logic Clk   = 1'b0;
   logic Reset = 1'b1;

   int checks = 0;
   int errors = 0;

   ctrl_seq_decoder_if #(.MCODEBITS(MCODEBITS), .OPWIDTH(OPWIDTH)) bus ();

   ctrl_seq_decoder #(.MCODEBITS(MCODEBITS), .OPWIDTH(OPWIDTH), .MEMLAT(MEMLAT)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   // Model state: remaining stall cycles, open movi pair, predicted outputs.
   int      mStall = 0;
   bit      mPair  = 1'b0;
   bit      mValid = 1'b0;
   bundle_t mExp   = '0;
   int      mRetired = 0;
   int      mStallCnt = 0;
   int      mIllCnt = 0;

   bundle_t dutB;
   assign dutB = {bus.InstType, bus.Branch, bus.MemRead, bus.MemWrite,
                  bus.MemtoReg, bus.ALUSrc, bus.RegWrite, bus.ALUOp, bus.illegal};

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Control bundle straight from the opcode table.
   function automatic bundle_t predict(input int op, input bit pairOpen);
      bundle_t b;
      b = '0;
      b.regWrite = 1'b1;
      b.aluOp    = 4'(op % 16);
      if (pairOpen && op != 25) begin
         b.regWrite = 1'b0;
         b.illegal  = 1'b1;
      end else if (op <= 1 || (op >= 7 && op <= 15)) begin
         b.aluSrc = 1'b0;
      end else if (op == 2) begin
         b.aluSrc = 1'b1;
      end else if (op == 3) begin
         b.aluSrc = 1'b1; b.memRead = 1'b1; b.memtoReg = 1'b1;
      end else if (op == 4) begin
         b.aluSrc = 1'b1; b.memWrite = 1'b1; b.regWrite = 1'b0;
      end else if (op == 5 || op == 6) begin
         b.branch = 1'b1; b.regWrite = 1'b0;
      end else if (op == 17) begin
         b.instType = 2'd2; b.aluSrc = 1'b1;
      end else if (op == 25) begin
         b.instType = 2'd3; b.aluSrc = 1'b1;
      end else begin
         b.regWrite = 1'b0;
         b.illegal  = 1'b1;
      end
      return b;
   endfunction

   task automatic modelReset();
      mStall = 0; mPair = 1'b0; mValid = 1'b0; mExp = '0;
      mRetired = 0; mStallCnt = 0; mIllCnt = 0;
   endtask

   // Advance the model by one rising edge using the inputs now applied.
   task automatic modelStep();
      bit rdy;
      int op;
      rdy = (mStall == 0);
      op  = int'(bus.instr);
      if (mValid && !mExp.illegal && mRetired < 65535) mRetired++;
      if (bus.instr_valid && !rdy && mStallCnt < 65535) mStallCnt++;
      if (mValid && mExp.illegal && mIllCnt < 255) mIllCnt++;
      if (bus.flush) begin
         mValid = 1'b0; mStall = 0; mPair = 1'b0;
      end else if (bus.instr_valid && rdy) begin
         mExp   = predict(op, mPair);
         mValid = 1'b1;
         mStall = (!mPair && (op == 3 || op == 4)) ? MEMLAT : 0;
         mPair  = !mPair && (op == 17);
      end else begin
         mValid = 1'b0;
         if (mStall > 0) mStall--;
      end
   endtask

   // Drive inputs, let one edge consume them, return #2 after that edge.
   task automatic applyStimulus(input bit v, input int op, input bit f);
      bus.instr_valid = v;
      bus.instr       = MCODEBITS'(op);
      bus.flush       = f;
      @(posedge Clk);
      if (!Reset) modelStep();
      #2;
   endtask

   task automatic pulseReset();
      Reset = 1'b1;
      modelReset();
      @(posedge Clk);
      #2;
      Reset = 1'b0;
   endtask

   // Per-cycle comparison of every meaningful output against the model.
   always @(negedge Clk) begin
      if (!Reset) begin
         checkOutput("instr_ready", int'(bus.instr_ready), int'(mStall == 0));
         checkOutput("ctl_valid", int'(bus.ctl_valid), int'(mValid));
         checkOutput("illegal", int'(bus.illegal), int'(mValid && mExp.illegal));
         if (mValid) checkOutput("bundle", int'(dutB), int'(mExp));
`ifdef CTRL_PERF_EN
         checkOutput("perf_retired", int'(bus.perf_retired), mRetired);
         checkOutput("perf_stall", int'(bus.perf_stall), mStallCnt);
         checkOutput("perf_illegal", int'(bus.perf_illegal), mIllCnt);
`endif
      end
   end

   initial begin
      int n;
      int k;
      int op;
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      bus.flush       = 1'b0;
      modelReset();
      @(posedge Clk); #2;
      @(posedge Clk); #2;
      checkOutput("rst_ctl_valid", int'(bus.ctl_valid), 0);
      checkOutput("rst_illegal", int'(bus.illegal), 0);
      checkOutput("rst_regwrite", int'(bus.RegWrite), 0);
      checkOutput("rst_aluop", int'(bus.ALUOp), 0);
      Reset = 1'b0;
      applyStimulus(1'b0, 0, 1'b0);
      checkOutput("rst_ready", int'(bus.instr_ready), 1);

      // Reset in the middle of a memory wait, then a plain add.
      applyStimulus(1'b1, 3, 1'b0);
      checkOutput("mid_lb_ready", int'(bus.instr_ready), 0);
      Reset = 1'b1;
      modelReset();
      #1;
      checkOutput("mid_rst_ctl_valid", int'(bus.ctl_valid), 0);
      @(posedge Clk); #2;
      Reset = 1'b0;
      applyStimulus(1'b1, 0, 1'b0);
      checkOutput("add_ctl_valid", int'(bus.ctl_valid), 1);
      checkOutput("add_aluop", int'(bus.ALUOp), 0);
      checkOutput("add_alusrc", int'(bus.ALUSrc), 0);
      checkOutput("add_regwrite", int'(bus.RegWrite), 1);
      checkOutput("add_illegal", int'(bus.illegal), 0);

      // lb with an add held behind it.
      applyStimulus(1'b1, 3, 1'b0);
      checkOutput("lb_memread", int'(bus.MemRead), 1);
      checkOutput("lb_memtoreg", int'(bus.MemtoReg), 1);
      n = 0;
      while (!bus.instr_ready && n < 8) begin
         applyStimulus(1'b1, 0, 1'b0);
         n++;
      end
      checkOutput("lb_stall_cycles", n, 2);
      checkOutput("lb_no_repeat", int'(bus.ctl_valid), 0);
      applyStimulus(1'b1, 0, 1'b0);
      checkOutput("add_after_lb_valid", int'(bus.ctl_valid), 1);
      checkOutput("add_after_lb_memread", int'(bus.MemRead), 0);

      // movi pair with idle gap, then a broken pair.
      applyStimulus(1'b1, 17, 1'b0);
      checkOutput("movihi_type", int'(bus.InstType), 2);
      checkOutput("movihi_illegal", int'(bus.illegal), 0);
      applyStimulus(1'b0, 0, 1'b0);
      applyStimulus(1'b0, 0, 1'b0);
      applyStimulus(1'b1, 25, 1'b0);
      checkOutput("movilo_type", int'(bus.InstType), 3);
      checkOutput("movilo_illegal", int'(bus.illegal), 0);
      applyStimulus(1'b1, 17, 1'b0);
      applyStimulus(1'b1, 1, 1'b0);
      checkOutput("broken_valid", int'(bus.ctl_valid), 1);
      checkOutput("broken_regwrite", int'(bus.RegWrite), 0);
      checkOutput("broken_illegal", int'(bus.illegal), 1);
      applyStimulus(1'b1, 1, 1'b0);
      checkOutput("after_broken_regwrite", int'(bus.RegWrite), 1);
      checkOutput("after_broken_illegal", int'(bus.illegal), 0);

      // Undefined opcode.
      applyStimulus(1'b1, 22, 1'b0);
      checkOutput("undef_valid", int'(bus.ctl_valid), 1);
      checkOutput("undef_regwrite", int'(bus.RegWrite), 0);
      checkOutput("undef_memwrite", int'(bus.MemWrite), 0);
      checkOutput("undef_illegal", int'(bus.illegal), 1);
      applyStimulus(1'b0, 0, 1'b0);
      checkOutput("undef_pulse_end", int'(bus.illegal), 0);

      // sb on the same edge as flush.
      applyStimulus(1'b1, 4, 1'b1);
      checkOutput("flush_sb_valid", int'(bus.ctl_valid), 0);
      checkOutput("flush_sb_ready", int'(bus.instr_ready), 1);
      applyStimulus(1'b0, 0, 1'b0);
      checkOutput("flush_no_memwait", int'(bus.instr_ready), 1);

`ifdef CTRL_PERF_EN
      pulseReset();
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 0, 1'b0);
      applyStimulus(1'b1, 3, 1'b0);
      n = 0;
      while (!bus.instr_ready && n < 8) begin
         applyStimulus(1'b1, 22, 1'b0);
         n++;
      end
      applyStimulus(1'b1, 22, 1'b0);
      applyStimulus(1'b0, 0, 1'b0);
      applyStimulus(1'b0, 0, 1'b0);
      checkOutput("perf_retired_lit", int'(bus.perf_retired), 4);
      checkOutput("perf_stall_lit", int'(bus.perf_stall), 2);
      checkOutput("perf_illegal_lit", int'(bus.perf_illegal), 1);
`endif

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            pulseReset();
         end else begin
            k = int'($urandom_range(0, 9));
            if (k < 3) begin
               case ($urandom_range(0, 3))
                  0: op = 3;
                  1: op = 4;
                  2: op = 17;
                  default: op = 25;
               endcase
            end else if (k < 6) begin
               op = int'($urandom_range(0, 15));
            end else begin
               op = int'($urandom_range(0, 31));
            end
            applyStimulus($urandom_range(0, 9) < 7, op, $urandom_range(0, 19) == 0);
         end
      end
      applyStimulus(1'b0, 0, 1'b0);
      @(negedge Clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
